// File: rtl/cl_ocl_cfg_demux.sv
// cl_ocl_cfg_demux: AXI-Lite slave to cfg-bus demultiplexer for the OCL BAR.
// One access in flight; the slot is picked from addr[SEL_LSB +: SEL_W].
// Slots >= NUM_SLV answer DECERR with UNMAPPED_DATA. Reads and writes
// share one FSM, and simultaneous requests alternate between read and write.
// Optional feature macro: CL_OCL_DEMUX_TIMEOUT_EN adds an ack timeout that
// answers SLVERR. Without it, WAIT_ACK waits for the ack indefinitely.
module cl_ocl_cfg_demux #(
  parameter int unsigned NUM_SLV       = 16,
  parameter int unsigned SEL_LSB       = 8,
  parameter int unsigned SEL_W         = 4,
  parameter int unsigned TIMEOUT_CYC   = 255,
  parameter logic [31:0] UNMAPPED_DATA = 32'hdead_beef
) (
  input  logic                  clk,
  input  logic                  sync_rst_n,
  input  logic                  flr_assert,
  input  logic [31:0]           awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           araddr,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           cfg_addr,
  output logic [31:0]           cfg_wdata,
  output logic [3:0]            cfg_wstrb,
  output logic [NUM_SLV-1:0]    cfg_wr,
  output logic [NUM_SLV-1:0]    cfg_rd,
  input  logic [NUM_SLV-1:0]    cfg_ack,
  input  logic [NUM_SLV*32-1:0] cfg_rdata,
  output logic [15:0]           err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               is_wr_q, is_wr_d;
  logic               last_wr_q, last_wr_d;
  logic               bvalid_q, bvalid_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_SLV-1:0] cfg_wr_q, cfg_wr_d;
  logic [NUM_SLV-1:0] cfg_rd_q, cfg_rd_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
`ifdef CL_OCL_DEMUX_TIMEOUT_EN
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
`endif

  logic               ack_sel_s;
  logic [31:0]        rdata_sel_s;
  logic               fin_s;
  logic [1:0]         fin_resp_s;
  logic [31:0]        fin_data_s;
  logic               err_inc_s;

  function automatic logic [SEL_W-1:0] slot_of(input logic [31:0] a);
    return a[SEL_LSB +: SEL_W];
  endfunction

  function automatic logic slot_mapped(input logic [SEL_W-1:0] s);
    return (32'(s) < NUM_SLV);
  endfunction

  // Pick the ack and read data of the slot addressed by the current access.
  always_comb begin
    ack_sel_s   = 1'b0;
    rdata_sel_s = 32'h0000_0000;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      ack_sel_s   = (32'(slot_of(addr_q)) == 32'(i)) ? cfg_ack[i] : ack_sel_s;
      rdata_sel_s = (32'(slot_of(addr_q)) == 32'(i)) ? cfg_rdata[32*i +: 32] : rdata_sel_s;
    end
  end

  // Next-state, handshake and response computation; FLR overrides everything.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    is_wr_d    = is_wr_q;
    last_wr_d  = last_wr_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    bresp_d    = bresp_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    cfg_wr_d   = '0;
    cfg_rd_d   = '0;
    awready    = 1'b0;
    arready    = 1'b0;
    wready     = 1'b0;
    fin_s      = 1'b0;
    fin_resp_s = 2'b00;
    fin_data_s = 32'h0000_0000;
    err_inc_s  = 1'b0;
`ifdef CL_OCL_DEMUX_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Write wins unless both request and the last completed one was a write.
        if (awvalid && (!arvalid || !last_wr_q)) begin
          awready = 1'b1;
          addr_d  = awaddr;
          is_wr_d = 1'b1;
          state_d = ST_WR_DATA;
        end else if (arvalid) begin
          arready = 1'b1;
          addr_d  = araddr;
          is_wr_d = 1'b0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        wready = wvalid;
        if (wvalid) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
          state_d = ST_REQ;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_REQ: begin
        if (slot_mapped(slot_of(addr_q))) begin
          state_d = ST_WAIT_ACK;
`ifdef CL_OCL_DEMUX_TIMEOUT_EN
          tmo_cnt_d = 16'h0000;
`endif
        end else begin
          fin_s      = 1'b1;
          fin_resp_s = 2'b11;
          fin_data_s = UNMAPPED_DATA;
          err_inc_s  = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sel_s) begin
          fin_s      = 1'b1;
          fin_resp_s = 2'b00;
          fin_data_s = rdata_sel_s;
        end else begin
`ifdef CL_OCL_DEMUX_TIMEOUT_EN
          // The pulse cycle counts as the first waited cycle, hence the +2.
          if ((32'(tmo_cnt_q) + 32'd2) >= TIMEOUT_CYC) begin
            fin_s      = 1'b1;
            fin_resp_s = 2'b10;
            fin_data_s = UNMAPPED_DATA;
            err_inc_s  = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
`else
          state_d = ST_WAIT_ACK;
`endif
        end
      end
      ST_RESP: begin
        if (is_wr_q ? bready : rready) begin
          bvalid_d  = 1'b0;
          rvalid_d  = 1'b0;
          last_wr_d = is_wr_q;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fin_s) begin
      state_d = ST_RESP;
      if (is_wr_q) begin
        bvalid_d = 1'b1;
        bresp_d  = fin_resp_s;
      end else begin
        rvalid_d = 1'b1;
        rresp_d  = fin_resp_s;
        rdata_d  = fin_data_s;
      end
    end else begin
      state_d = state_d;
    end

    err_cnt_d = (err_inc_s && (err_cnt_q != 16'hffff)) ? (err_cnt_q + 16'd1) : err_cnt_q;

    // Pulses are registered, so they are raised on entry into REQ.
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      cfg_wr_d[i] = (state_d == ST_REQ) && (32'(slot_of(addr_d)) == 32'(i)) && is_wr_d;
      cfg_rd_d[i] = (state_d == ST_REQ) && (32'(slot_of(addr_d)) == 32'(i)) && !is_wr_d;
    end

    if (flr_assert) begin
      state_d   = ST_IDLE;
      awready   = 1'b0;
      arready   = 1'b0;
      wready    = 1'b0;
      bvalid_d  = 1'b0;
      rvalid_d  = 1'b0;
      cfg_wr_d  = '0;
      cfg_rd_d  = '0;
      err_cnt_d = err_cnt_q;
      last_wr_d = last_wr_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      is_wr_q   <= 1'b0;
      last_wr_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0000_0000;
      cfg_wr_q  <= '0;
      cfg_rd_q  <= '0;
      err_cnt_q <= 16'h0000;
`ifdef CL_OCL_DEMUX_TIMEOUT_EN
      tmo_cnt_q <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      is_wr_q   <= is_wr_d;
      last_wr_q <= last_wr_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      cfg_wr_q  <= cfg_wr_d;
      cfg_rd_q  <= cfg_rd_d;
      err_cnt_q <= err_cnt_d;
`ifdef CL_OCL_DEMUX_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign bvalid    = bvalid_q;
  assign rvalid    = rvalid_q;
  assign bresp     = bresp_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign cfg_addr  = addr_q;
  assign cfg_wdata = wdata_q;
  assign cfg_wstrb = wstrb_q;
  assign cfg_wr    = cfg_wr_q;
  assign cfg_rd    = cfg_rd_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cl_ocl_cfg_demux.sv
// Directed bench for cl_ocl_cfg_demux (NUM_SLV=6, TIMEOUT_CYC=8) with a
// response scoreboard and a simple cfg-bus target model.
module tb_cl_ocl_cfg_demux;
  localparam int NS = 6;

  logic          clk = 1'b0;
  logic          sync_rst_n, flr_assert;
  logic [31:0]   awaddr, araddr, wdata, rdata, cfg_addr, cfg_wdata;
  logic          awvalid, awready, arvalid, arready, wvalid, wready;
  logic [3:0]    wstrb, cfg_wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, rvalid, rready;
  logic [NS-1:0] cfg_wr, cfg_rd, cfg_ack, resp_ack, man_ack, responsive;
  logic [NS*32-1:0] cfg_rdata;
  logic [15:0]   err_cnt;

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  logic hs_order[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, resp_cnt = 0, wr_pulse_cnt = 0, rd_pulse_cnt = 0;
  int   last_aw_cyc = 0, last_ar_cyc = 0, last_pulse_cyc = 0, last_resp_cyc = 0;
  logic [NS-1:0] last_pulse_vec;
  logic [31:0]   last_cfg_addr, last_cfg_wdata;
  logic [3:0]    last_cfg_wstrb;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign cfg_ack = resp_ack | man_ack;

  cl_ocl_cfg_demux #(
    .NUM_SLV(NS), .SEL_LSB(8), .SEL_W(4), .TIMEOUT_CYC(8), .UNMAPPED_DATA(32'hdead_beef)
  ) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .flr_assert(flr_assert),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Target model: every responsive slot acks one cycle after its pulse.
  initial begin
    logic [NS-1:0] pend;
    pend = '0;
    resp_ack = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = pend;
      pend = (cfg_wr | cfg_rd) & responsive;
    end
  end

  // Monitor: handshakes, pulses and responses checked against the scoreboard.
  always @(negedge clk) begin
    if (sync_rst_n) begin
      if (awvalid && awready) begin last_aw_cyc = cyc; hs_order.push_back(1'b1); end
      if (arvalid && arready) begin last_ar_cyc = cyc; hs_order.push_back(1'b0); end
      if (|(cfg_wr | cfg_rd)) begin
        last_pulse_cyc = cyc;
        last_pulse_vec = cfg_wr | cfg_rd;
        last_cfg_addr  = cfg_addr;
        last_cfg_wdata = cfg_wdata;
        last_cfg_wstrb = cfg_wstrb;
        if (|cfg_wr) wr_pulse_cnt++;
        if (|cfg_rd) rd_pulse_cnt++;
      end
      if (bvalid && bready) begin
        chk("sb_nonempty_b", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("b_direction", 32'd1, 32'(e.is_wr));
          chk("bresp", 32'(bresp), 32'(e.resp));
        end
        resp_cnt++;
        last_resp_cyc = cyc;
      end
      if (rvalid && rready) begin
        chk("sb_nonempty_r", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("r_direction", 32'd0, 32'(e.is_wr));
          chk("rresp", 32'(rresp), 32'(e.resp));
          chk("rdata", rdata, e.data);
        end
        resp_cnt++;
        last_resp_cyc = cyc;
      end
    end
  end

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = awready; end
    chk("aw_handshake", 32'(got), 32'd1);
    @(posedge clk); #1; awvalid = 1'b0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = wready; end
    chk("w_handshake", 32'(got), 32'd1);
    @(posedge clk); #1; wvalid = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a);
    logic got;
    araddr = a; arvalid = 1'b1; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = arready; end
    chk("ar_handshake", 32'(got), 32'd1);
    @(posedge clk); #1; arvalid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int k = 0; k < 60 && resp_cnt < target; k++) begin @(negedge clk); #1; end
    chk("resp_arrived", 32'(resp_cnt >= target), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int base_resp, base_wr, base_rd, base_hs, n_hs, exp_err;
    exp_err = 0;
    sync_rst_n = 1'b0; flr_assert = 1'b0;
    awaddr = 32'h0; araddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    man_ack = '0; responsive = 6'b111011;
    for (int i = 0; i < NS; i++) cfg_rdata[32*i +: 32] = 32'h4444_0000 | 32'(i);
    cfg_rdata[32*5 +: 32] = 32'hcafe_f00d;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_readies", {29'h0, awready, arready, wready}, 32'h0);
    chk("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
    chk("rst_resps", {28'h0, bresp, rresp}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_cfg_pulses", {20'h0, cfg_wr, cfg_rd}, 32'h0);
    chk("rst_cfg_addr", cfg_addr, 32'h0);
    chk("rst_cfg_wdata", cfg_wdata, 32'h0);
    chk("rst_cfg_wstrb", 32'(cfg_wstrb), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    sync_rst_n = 1'b1;
    @(posedge clk); #1;

    // Mapped write to slot 3
    base_resp = resp_cnt; base_wr = wr_pulse_cnt;
    sb_q.push_back('{1'b1, 2'b00, 32'h0});
    issue_write(32'h0000_0312, 32'h1234_5678, 4'hf);
    wait_resp(base_resp + 1);
    chk("wr_pulse_count", 32'(wr_pulse_cnt - base_wr), 32'd1);
    chk("wr_pulse_slot", 32'(last_pulse_vec), 32'h08);
    chk("wr_cfg_addr", last_cfg_addr, 32'h0000_0312);
    chk("wr_cfg_wdata", last_cfg_wdata, 32'h1234_5678);
    chk("wr_cfg_wstrb", 32'(last_cfg_wstrb), 32'hf);
    chk("wr_pulse_latency", 32'(last_pulse_cyc - last_aw_cyc), 32'd2);
    chk("wr_resp_latency", 32'(last_resp_cyc - last_aw_cyc), 32'd4);

    // Mapped read from slot 5
    base_resp = resp_cnt; base_rd = rd_pulse_cnt;
    sb_q.push_back('{1'b0, 2'b00, 32'hcafe_f00d});
    issue_read(32'h0000_0504);
    wait_resp(base_resp + 1);
    chk("rd_pulse_count", 32'(rd_pulse_cnt - base_rd), 32'd1);
    chk("rd_pulse_slot", 32'(last_pulse_vec), 32'h20);
    chk("rd_pulse_latency", 32'(last_pulse_cyc - last_ar_cyc), 32'd1);
    chk("rd_resp_latency", 32'(last_resp_cyc - last_ar_cyc), 32'd3);

    // Unmapped read (slot 10 >= NUM_SLV)
    base_resp = resp_cnt; base_rd = rd_pulse_cnt; base_wr = wr_pulse_cnt;
    sb_q.push_back('{1'b0, 2'b11, 32'hdead_beef});
    issue_read(32'h0000_0a00);
    wait_resp(base_resp + 1);
    exp_err++;
    chk("unmapped_rd_no_pulse", 32'((rd_pulse_cnt - base_rd) + (wr_pulse_cnt - base_wr)), 32'd0);
    chk("unmapped_rd_latency", 32'(last_resp_cyc - last_ar_cyc), 32'd2);
    chk("unmapped_rd_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Unmapped write
    base_resp = resp_cnt; base_wr = wr_pulse_cnt;
    sb_q.push_back('{1'b1, 2'b11, 32'h0});
    issue_write(32'h0000_0f04, 32'h0bad_0bad, 4'h3);
    wait_resp(base_resp + 1);
    exp_err++;
    chk("unmapped_wr_no_pulse", 32'(wr_pulse_cnt - base_wr), 32'd0);
    chk("unmapped_wr_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Partial-strobe write to slot 1, then a read so the last completed is a read
    base_resp = resp_cnt;
    sb_q.push_back('{1'b1, 2'b00, 32'h0});
    issue_write(32'h0000_0104, 32'haabb_ccdd, 4'h5);
    wait_resp(base_resp + 1);
    chk("strb_cfg_wstrb", 32'(last_cfg_wstrb), 32'h5);
    chk("strb_pulse_slot", 32'(last_pulse_vec), 32'h02);
    base_resp = resp_cnt;
    sb_q.push_back('{1'b0, 2'b00, 32'h4444_0000});
    issue_read(32'h0000_0000);
    wait_resp(base_resp + 1);

    // Arbitration: awvalid and arvalid held together for four transactions
    base_resp = resp_cnt; base_hs = hs_order.size(); n_hs = 0;
    sb_q.push_back('{1'b1, 2'b00, 32'h0});
    sb_q.push_back('{1'b0, 2'b00, 32'h4444_0004});
    sb_q.push_back('{1'b1, 2'b00, 32'h0});
    sb_q.push_back('{1'b0, 2'b00, 32'h4444_0004});
    awaddr = 32'h0000_0010; wdata = 32'h0000_00a0; wstrb = 4'hf;
    araddr = 32'h0000_0400;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int k = 0; k < 200 && n_hs < 4; k++) begin
      @(negedge clk);
      if (awready || arready) n_hs++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("arb_hs_count", 32'(n_hs), 32'd4);
    wait_resp(base_resp + 4);
    chk("arb_hs_recorded", 32'(hs_order.size() - base_hs), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base_hs + i < hs_order.size())
        chk("arb_order", 32'(hs_order[base_hs + i]), ((i % 2) == 0) ? 32'd1 : 32'd0);
    end

`ifdef CL_OCL_DEMUX_TIMEOUT_EN
    // Slot 2 never acks: SLVERR eight cycles after the pulse
    base_resp = resp_cnt;
    sb_q.push_back('{1'b0, 2'b10, 32'hdead_beef});
    issue_read(32'h0000_0200);
    wait_resp(base_resp + 1);
    exp_err++;
    chk("tmo_latency", 32'(last_resp_cyc - last_pulse_cyc), 32'd8);
    chk("tmo_err_cnt", 32'(err_cnt), 32'(exp_err));
`endif

    // FLR during WAIT_ACK on unresponsive slot 2; wrong-slot and late acks ignored
    base_resp = resp_cnt; base_wr = wr_pulse_cnt;
    issue_write(32'h0000_0208, 32'h5555_aaaa, 4'hf);
    @(posedge clk); #1;
    man_ack = 6'b001000;
    araddr = 32'h0000_0504; arvalid = 1'b1;
    @(negedge clk);
    chk("wait_ack_readies", {29'h0, awready, arready, wready}, 32'h0);
    @(posedge clk); #1;
    man_ack = '0; arvalid = 1'b0; flr_assert = 1'b1;
    @(posedge clk); #1;
    flr_assert = 1'b0;
    @(posedge clk); #1;
    man_ack = 6'b000100;
    @(posedge clk); #1;
    man_ack = '0;
    repeat (10) @(posedge clk);
    #1;
    chk("flr_pulse_once", 32'(wr_pulse_cnt - base_wr), 32'd1);
    chk("flr_no_response", 32'(resp_cnt - base_resp), 32'd0);
    chk("flr_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Normal transaction after the abort
    base_resp = resp_cnt;
    sb_q.push_back('{1'b0, 2'b00, 32'hcafe_f00d});
    issue_read(32'h0000_0504);
    wait_resp(base_resp + 1);
    chk("post_flr_latency", 32'(last_resp_cyc - last_ar_cyc), 32'd3);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
